core_rc_ctrl: RTL and testbench
===============================

// Module: core_rc_ctrl
// PURPOSE
//  Sequencer for one recompute (RC) datapath lane. Per row it queues RMS scale
//  factors from the upstream RMS unit and loads one into the lane, then counts
//  the row's results out and clears the scale before loading the next row's
//  scale. It also drives the lane's recompute mode and shift, and keeps sticky
//  error status. Sits between the RMS scale producer and the RC lane.
// PARAMETERS
//  SCALE_Q_DEPTH  2   scale queue entries (power of 2, >=2)
//  ROW_LEN_W      10  width of tokens-per-row count
//  ROW_CNT_W      8   width of rows-per-job count
// PORTS
//  clk               in   1          clock, all logic on posedge
//  rst               in   1          async reset, active-high
//  start             in   1          1-cycle job start pulse; ignored unless IDLE
//  abort             in   1          return to IDLE, flush queue
//  cfg_recompute_en  in   1          job uses scaling (else bypass)
//  cfg_row_len       in   ROW_LEN_W  tokens per row, 0 treated as 1
//  cfg_num_rows      in   ROW_CNT_W  rows per job, 0 treated as 1
//  cfg_shift         in   5          right shift for the lane
//  scale_in          in   24         signed scale from RMS unit
//  scale_in_vld      in   1          scale valid
//  scale_in_rdy      out  1          queue not full
//  dp_out_vld        in   1          lane result valid
//  dp_error          in   1          lane input-FIFO full flag
//  recompute_needed  out  1          lane mode
//  rc_scale          out  24         scale to lane
//  rc_scale_vld      out  1          1-cycle scale load
//  rc_scale_clear    out  1          1-cycle scale invalidate
//  rms_rc_shift      out  5          shift to lane
//  row_done          out  1          1-cycle pulse per finished row
//  busy              out  1          state != IDLE
//  err_sticky        out  2          [0] dp_error seen, [1] stray dp_out_vld
//  err_clr           in   1          clears err_sticky
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, queue empty, counters 0. scale_in_rdy is
//   1 one cycle after rst deasserts.
//  Config (mode, row length, row count, shift) is latched on start in IDLE.
//   recompute_needed and rms_rc_shift hold the latched values until the next start.
//  Queue: push when scale_in_vld && scale_in_rdy. scale_in_rdy = !full, so there
//   is no push when full. A push and a pop in the same cycle are allowed. Pushes
//   are accepted in any state.
//  FSM states:
//   IDLE   -> LOAD on start. If recompute is disabled, go to RUN instead.
//   LOAD   when queue not empty: pop. Next cycle rc_scale_vld=1 and rc_scale=popped
//          value. Then go to RUN.
//   RUN    count dp_out_vld. When the count reaches row_len go to CLEAR. This
//          covers the case where dp_out_vld and the final count arrive together.
//   CLEAR  1 cycle: rc_scale_clear=1 (only if recompute), row_done=1, rows_left--.
//          Then go to IDLE if rows_left was 1. Otherwise go to LOAD, or RUN in bypass.
//  rc_scale_vld and rc_scale_clear are never high in the same cycle.
//  rc_scale holds its last loaded value between loads.
//  dp_out_vld outside RUN sets err_sticky[1]; the token is not counted.
//  dp_error sets err_sticky[0].
//  err_clr clears err_sticky. A set and an err_clr in the same cycle leave the bit set.
//  abort in any state: next cycle IDLE, queue flushed, counters zeroed.
//   rc_scale_clear pulses once if a scale was loaded and not yet cleared.
//   abort takes priority over start.
//  Reset asserted mid-job: immediate return to reset values. There is no clear pulse.
// TESTING
//  Recompute mode, row_len=4, rows=2, scales 0x000100 and 0x000200 pushed ->
//   rc_scale_vld with 0x000100; 4 out_vld give clear and row_done; then vld with 0x000200; busy=0 at end.
//  Bypass mode, row_len=3, rows=1 -> no rc_scale_vld or clear; row_done after 3rd out_vld.
//  Queue fill: 3 scales back-to-back with depth 2 -> scale_in_rdy=0 on the 3rd; 3rd accepted after first pop.
//  Stray out_vld in IDLE -> err_sticky=2'b10; err_clr -> 2'b00; dp_error pulse -> 2'b01.
//  abort during RUN after load -> one rc_scale_clear, IDLE, queue empty, rdy=1.
//  start and abort in the same cycle in IDLE -> stays IDLE, busy=0.

Source files
------------

// File: rtl/core_rc_ctrl_if.sv
// Scale handshake and lane-facing bus between the RMS scale producer, core_rc_ctrl and the RC lane.
// slave is the controller side; master is the upstream/lane side.
interface core_rc_ctrl_if;
    logic [23:0] scale_in;
    logic        scale_in_vld;
    logic        scale_in_rdy;
    logic        dp_out_vld;
    logic        dp_error;
    logic        recompute_needed;
    logic [23:0] rc_scale;
    logic        rc_scale_vld;
    logic        rc_scale_clear;
    logic [4:0]  rms_rc_shift;

    modport master (
        output scale_in, scale_in_vld, dp_out_vld, dp_error,
        input  scale_in_rdy, recompute_needed, rc_scale, rc_scale_vld,
               rc_scale_clear, rms_rc_shift
    );

    modport slave (
        input  scale_in, scale_in_vld, dp_out_vld, dp_error,
        output scale_in_rdy, recompute_needed, rc_scale, rc_scale_vld,
               rc_scale_clear, rms_rc_shift
    );
endinterface

// File: rtl/core_rc_ctrl.sv
// Recompute-lane sequencer: queues RMS scales, loads one per row, counts the row's
// results out, clears the scale, and tracks sticky lane error status.
module core_rc_ctrl #(
    parameter int SCALE_Q_DEPTH = 2,
    parameter int ROW_LEN_W     = 10,
    parameter int ROW_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic                 i_cfg_recompute_en,
    input  logic [ROW_LEN_W-1:0] i_cfg_row_len,
    input  logic [ROW_CNT_W-1:0] i_cfg_num_rows,
    input  logic [4:0]           i_cfg_shift,
    input  logic                 i_err_clr,
    output logic                 o_row_done,
    output logic                 o_busy,
    output logic [1:0]           o_err_sticky,
    core_rc_ctrl_if.slave        bus
);

    localparam int PW = $clog2(SCALE_Q_DEPTH);
    localparam logic [PW:0] QFULL = (PW+1)'(SCALE_Q_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_CLEAR} state_t;

    // Scale queue
    logic [23:0]          r_q [SCALE_Q_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [PW:0]          r_count;
    logic [PW:0]          w_count_nxt;
    logic                 r_rdy;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;

    // Sequencer
    state_t               r_state;
    logic                 r_busy;
    logic                 r_mode;
    logic [4:0]           r_shift;
    logic [ROW_LEN_W-1:0] r_row_len;
    logic [ROW_LEN_W-1:0] r_tok_cnt;
    logic [ROW_LEN_W-1:0] w_tok_inc;
    logic [ROW_CNT_W-1:0] r_rows_left;
    logic [23:0]          r_rc_scale;
    logic                 r_rc_scale_vld;
    logic                 r_rc_scale_clear;
    logic                 r_row_done;
    logic                 r_loaded;
    logic [1:0]           r_err;
    logic                 w_stray;

    assign w_empty   = (r_count == '0);
    assign w_push    = bus.scale_in_vld && r_rdy && !i_abort;
    assign w_pop     = (r_state == ST_LOAD) && !w_empty && !i_abort;
    assign w_tok_inc = r_tok_cnt + ROW_LEN_W'(1);
    assign w_stray   = bus.dp_out_vld && (r_state != ST_RUN);

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (PW+1)'(1);
            2'b01:   w_count_nxt = r_count - (PW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SCALE_Q_DEPTH; i++) r_q[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdy    <= 1'b0;
        end else if (i_abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdy    <= 1'b1;
        end else begin
            if (w_push) begin
                r_q[r_wr_ptr] <= bus.scale_in;
                r_wr_ptr      <= r_wr_ptr + PW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_count_nxt;
            // Registered ready tracks the post-update occupancy, so it never admits a push when full
            r_rdy   <= (w_count_nxt != QFULL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_busy           <= 1'b0;
            r_mode           <= 1'b0;
            r_shift          <= '0;
            r_row_len        <= '0;
            r_tok_cnt        <= '0;
            r_rows_left      <= '0;
            r_rc_scale       <= '0;
            r_rc_scale_vld   <= 1'b0;
            r_rc_scale_clear <= 1'b0;
            r_row_done       <= 1'b0;
            r_loaded         <= 1'b0;
        end else begin
            r_rc_scale_vld   <= 1'b0;
            r_rc_scale_clear <= 1'b0;
            r_row_done       <= 1'b0;
            if (i_abort) begin
                r_state          <= ST_IDLE;
                r_busy           <= 1'b0;
                r_tok_cnt        <= '0;
                r_rows_left      <= '0;
                r_rc_scale_clear <= r_loaded;
                r_loaded         <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            r_mode      <= i_cfg_recompute_en;
                            r_shift     <= i_cfg_shift;
                            r_row_len   <= (i_cfg_row_len == '0) ? ROW_LEN_W'(1) : i_cfg_row_len;
                            r_rows_left <= (i_cfg_num_rows == '0) ? ROW_CNT_W'(1) : i_cfg_num_rows;
                            r_tok_cnt   <= '0;
                            r_busy      <= 1'b1;
                            r_state     <= i_cfg_recompute_en ? ST_LOAD : ST_RUN;
                        end
                    end
                    ST_LOAD: begin
                        if (!w_empty) begin
                            r_rc_scale     <= r_q[r_rd_ptr];
                            r_rc_scale_vld <= 1'b1;
                            r_loaded       <= 1'b1;
                            r_state        <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        // Row-end pulses are launched here so they are visible for the whole CLEAR cycle
                        if (bus.dp_out_vld) begin
                            if (w_tok_inc == r_row_len) begin
                                r_tok_cnt        <= '0;
                                r_row_done       <= 1'b1;
                                r_rc_scale_clear <= r_mode;
                                r_loaded         <= 1'b0;
                                r_state          <= ST_CLEAR;
                            end else begin
                                r_tok_cnt <= w_tok_inc;
                            end
                        end
                    end
                    ST_CLEAR: begin
                        r_rows_left <= r_rows_left - ROW_CNT_W'(1);
                        if (r_rows_left == ROW_CNT_W'(1)) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= r_mode ? ST_LOAD : ST_RUN;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // A set wins over a clear arriving in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_err <= '0;
        else     r_err <= (r_err & ~{2{i_err_clr}}) | {w_stray, bus.dp_error};
    end

    assign bus.scale_in_rdy     = r_rdy;
    assign bus.recompute_needed = r_mode;
    assign bus.rc_scale         = r_rc_scale;
    assign bus.rc_scale_vld     = r_rc_scale_vld;
    assign bus.rc_scale_clear   = r_rc_scale_clear;
    assign bus.rms_rc_shift     = r_shift;
    assign o_row_done           = r_row_done;
    assign o_busy               = r_busy;
    assign o_err_sticky         = r_err;

endmodule

// File: tb/tb_core_rc_ctrl.sv
// Scoreboard bench for core_rc_ctrl: stimulus queues expected lane events, a negedge
// monitor pops and compares them; state/status values are checked directly.
module tb_core_rc_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       cfg_en = 1'b0;
    logic [9:0] cfg_row_len = '0;
    logic [7:0] cfg_num_rows = '0;
    logic [4:0] cfg_shift = '0;
    logic       err_clr = 1'b0;
    logic       row_done;
    logic       busy;
    logic [1:0] err_sticky;

    core_rc_ctrl_if bus();

    core_rc_ctrl #(.SCALE_Q_DEPTH(2), .ROW_LEN_W(10), .ROW_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
        .i_cfg_recompute_en(cfg_en), .i_cfg_row_len(cfg_row_len),
        .i_cfg_num_rows(cfg_num_rows), .i_cfg_shift(cfg_shift),
        .i_err_clr(err_clr), .o_row_done(row_done), .o_busy(busy),
        .o_err_sticky(err_sticky), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_VLD = 0, EV_CLR = 1, EV_ROW = 2} ev_kind_t;
    typedef struct {
        ev_kind_t    k;
        logic [23:0] d;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic expect_ev(ev_kind_t k, logic [23:0] d);
        ev_t e;
        e.k = k;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(ev_kind_t k, logic [23:0] d);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected got_kind=%0d got_data=%h", int'(k), d);
        end else begin
            e = exp_q.pop_front();
            if (e.k != k || (k == EV_VLD && e.d !== d)) begin
                n_fail++;
                $display("FAIL sb_event got_kind=%0d got_data=%h exp_kind=%0d exp_data=%h",
                         int'(k), d, int'(e.k), e.d);
            end
        end
    endtask

    // Monitor: samples lane-facing outputs mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (bus.rc_scale_vld || bus.rc_scale_clear)
                check("vld_clr_exclusive", {31'd0, bus.rc_scale_vld && bus.rc_scale_clear}, 32'd0);
            if (bus.rc_scale_vld)   sb_pop(EV_VLD, bus.rc_scale);
            if (bus.rc_scale_clear) sb_pop(EV_CLR, 24'h0);
            if (row_done)           sb_pop(EV_ROW, 24'h0);
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_scale(logic [23:0] v);
        logic acc;
        bus.scale_in     = v;
        bus.scale_in_vld = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 64; i++) begin
            acc = bus.scale_in_rdy;
            cyc(1);
            if (acc) break;
        end
        bus.scale_in_vld = 1'b0;
        if (!acc) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rc_vld(string tag);
        for (int i = 0; i < 64; i++) begin
            if (bus.rc_scale_vld) return;
            cyc(1);
        end
        check({tag, "_vld_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(string tag);
        for (int i = 0; i < 64; i++) begin
            if (!busy) return;
            cyc(1);
        end
        check({tag, "_idle_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic tokens(int n);
        bus.dp_out_vld = 1'b1;
        cyc(n);
        bus.dp_out_vld = 1'b0;
    endtask

    task automatic start_job(logic en, logic [9:0] len, logic [7:0] rows, logic [4:0] sh);
        cfg_en       = en;
        cfg_row_len  = len;
        cfg_num_rows = rows;
        cfg_shift    = sh;
        start        = 1'b1;
        cyc(1);
        start        = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_iter;
        bus.scale_in     = '0;
        bus.scale_in_vld = 1'b0;
        bus.dp_out_vld   = 1'b0;
        bus.dp_error     = 1'b0;

        // Reset values
        cyc(3);
        check("rst_rdy", {31'd0, bus.scale_in_rdy}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {30'd0, err_sticky}, 32'd0);
        check("rst_scale", {8'd0, bus.rc_scale}, 32'd0);
        check("rst_mode", {31'd0, bus.recompute_needed}, 32'd0);
        rst = 1'b0;
        cyc(1);
        check("rdy_after_rst", {31'd0, bus.scale_in_rdy}, 32'd1);

        // Recompute, row_len=4, rows=2
        push_scale(24'h000100);
        push_scale(24'h000200);
        expect_ev(EV_VLD, 24'h000100); expect_ev(EV_CLR, '0); expect_ev(EV_ROW, '0);
        expect_ev(EV_VLD, 24'h000200); expect_ev(EV_CLR, '0); expect_ev(EV_ROW, '0);
        start_job(1'b1, 10'd4, 8'd2, 5'd7);
        check("rc_busy", {31'd0, busy}, 32'd1);
        check("rc_mode", {31'd0, bus.recompute_needed}, 32'd1);
        check("rc_shift", {27'd0, bus.rms_rc_shift}, 32'd7);
        wait_rc_vld("rc_row0");
        tokens(4);
        wait_rc_vld("rc_row1");
        tokens(4);
        wait_idle("rc");
        check("rc_busy_end", {31'd0, busy}, 32'd0);
        check("rc_scale_hold", {8'd0, bus.rc_scale}, 32'h000200);
        check("rc_shift_hold", {27'd0, bus.rms_rc_shift}, 32'd7);
        check("rc_err", {30'd0, err_sticky}, 32'd0);

        // Bypass, row_len=3, rows=1
        expect_ev(EV_ROW, '0);
        start_job(1'b0, 10'd3, 8'd1, 5'd3);
        check("bp_mode", {31'd0, bus.recompute_needed}, 32'd0);
        check("bp_shift", {27'd0, bus.rms_rc_shift}, 32'd3);
        tokens(3);
        wait_idle("bp");
        check("bp_busy_end", {31'd0, busy}, 32'd0);

        // Bypass with zero row length and zero rows acts as 1 and 1
        expect_ev(EV_ROW, '0);
        start_job(1'b0, 10'd0, 8'd0, 5'd0);
        tokens(1);
        wait_idle("zero");
        check("zero_err", {30'd0, err_sticky}, 32'd0);

        // Queue fill: third push stalls until the first pop
        push_scale(24'h00000A);
        push_scale(24'h00000B);
        check("q_full_rdy", {31'd0, bus.scale_in_rdy}, 32'd0);
        expect_ev(EV_VLD, 24'h00000A); expect_ev(EV_CLR, '0); expect_ev(EV_ROW, '0);
        expect_ev(EV_VLD, 24'h00000B); expect_ev(EV_CLR, '0); expect_ev(EV_ROW, '0);
        expect_ev(EV_VLD, 24'h00000C); expect_ev(EV_CLR, '0); expect_ev(EV_ROW, '0);
        bus.scale_in     = 24'h00000C;
        bus.scale_in_vld = 1'b1;
        start_job(1'b1, 10'd1, 8'd3, 5'd0);
        acc_iter = -1;
        fork
            begin
                for (int i = 0; i < 32; i++) begin
                    logic acc;
                    acc = bus.scale_in_rdy;
                    cyc(1);
                    if (acc) begin
                        acc_iter = i;
                        break;
                    end
                end
                bus.scale_in_vld = 1'b0;
            end
            begin
                repeat (3) begin
                    wait_rc_vld("qf");
                    tokens(1);
                end
            end
        join
        check("q_third_accept_cycle", acc_iter, 32'd1);
        wait_idle("qf");

        // Sticky errors
        bus.dp_out_vld = 1'b1;
        cyc(1);
        bus.dp_out_vld = 1'b0;
        check("err_stray", {30'd0, err_sticky}, 32'd2);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        check("err_clr", {30'd0, err_sticky}, 32'd0);
        bus.dp_error = 1'b1;
        cyc(1);
        bus.dp_error = 1'b0;
        check("err_dp", {30'd0, err_sticky}, 32'd1);
        bus.dp_error = 1'b1;
        err_clr      = 1'b1;
        cyc(1);
        bus.dp_error = 1'b0;
        err_clr      = 1'b0;
        check("err_set_wins", {30'd0, err_sticky}, 32'd1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        check("err_clr2", {30'd0, err_sticky}, 32'd0);

        // Abort during RUN after a load
        push_scale(24'h000333);
        push_scale(24'h000444);
        expect_ev(EV_VLD, 24'h000333); expect_ev(EV_CLR, '0);
        start_job(1'b1, 10'd5, 8'd2, 5'd1);
        wait_rc_vld("ab");
        push_scale(24'h000555);
        check("ab_full", {31'd0, bus.scale_in_rdy}, 32'd0);
        tokens(2);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        check("ab_busy", {31'd0, busy}, 32'd0);
        check("ab_rdy", {31'd0, bus.scale_in_rdy}, 32'd1);
        cyc(2);
        check("ab_err", {30'd0, err_sticky}, 32'd0);

        // Flushed queue: a new job waits in LOAD until a fresh scale arrives
        start_job(1'b1, 10'd1, 8'd1, 5'd0);
        cyc(6);
        check("flush_wait_busy", {31'd0, busy}, 32'd1);
        check("flush_no_vld", {31'd0, bus.rc_scale_vld}, 32'd0);
        expect_ev(EV_VLD, 24'h000666); expect_ev(EV_CLR, '0); expect_ev(EV_ROW, '0);
        push_scale(24'h000666);
        wait_rc_vld("fl");
        tokens(1);
        wait_idle("fl");

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        cfg_en = 1'b1;
        cyc(1);
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", {31'd0, busy}, 32'd0);
        cyc(2);
        check("sa_busy2", {31'd0, busy}, 32'd0);

        cyc(5);
        check("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
